// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types and constants for the two-port RAM arbiter.
//   - arb_state_t : access sequencer states (IDLE -> ISSUE -> RESP)
//   - port_t      : identifies a bus master port (A = instruction, B = data)
//   - RAM_ADDR_W / RAM_DATA_W : geometry of the on-chip RAM (4096 x 32)
package ram_arb_pkg;

  localparam int unsigned RAM_ADDR_W = 12;
  localparam int unsigned RAM_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin pick. Purely combinational.
//   req[0] = port A request, req[1] = port B request
//   last   = port granted most recently
//   winner = port to grant; with no request it simply echoes last
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last,
  output port_t      winner
);

  always_comb begin
    winner = last;
    case (req)
      2'b01:   winner = PORT_A;
      2'b10:   winner = PORT_B;
      2'b11:   winner = other_port(last);
      default: winner = last;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM between two Wishbone-classic
//   masters. One access at a time: IDLE (arbitrate, load RAM controls),
//   ISSUE (RAM samples), RESP (ack + read data). Ties alternate.
//
//   clk_i, rst_i                     clock, async active-high reset
//   a_* / b_*                        Wishbone classic slave ports A and B
//     cyc_i, stb_i, we_i, adr_i, sel_i, dat_i   request
//     dat_o, ack_o                               response
//   ram_we_o, ram_adr_o, ram_be_o, ram_dat_o    registered RAM controls
//   ram_dat_i                        RAM registered read data
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                a_cyc_i,
  input  logic                a_stb_i,
  input  logic                a_we_i,
  input  logic [ADDR_W-1:0]   a_adr_i,
  input  logic [DATA_W/8-1:0] a_sel_i,
  input  logic [DATA_W-1:0]   a_dat_i,
  output logic [DATA_W-1:0]   a_dat_o,
  output logic                a_ack_o,

  input  logic                b_cyc_i,
  input  logic                b_stb_i,
  input  logic                b_we_i,
  input  logic [ADDR_W-1:0]   b_adr_i,
  input  logic [DATA_W/8-1:0] b_sel_i,
  input  logic [DATA_W-1:0]   b_dat_i,
  output logic [DATA_W-1:0]   b_dat_o,
  output logic                b_ack_o,

  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_adr_o,
  output logic [DATA_W/8-1:0] ram_be_o,
  output logic [DATA_W-1:0]   ram_dat_o,
  input  logic [DATA_W-1:0]   ram_dat_i
);

  localparam int unsigned SEL_W = DATA_W / 8;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;

  // The granted port doubles as the round-robin history: it only changes
  // when a new grant is made, so it is always the port served last.
  port_t             r_grant;
  port_t             w_winner;

  logic              w_req_a;
  logic              w_req_b;
  logic              w_any_req;

  logic              w_mux_we;
  logic [ADDR_W-1:0] w_mux_adr;
  logic [SEL_W-1:0]  w_mux_sel;
  logic [DATA_W-1:0] w_mux_dat;

  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_adr;
  logic [SEL_W-1:0]  r_ram_be;
  logic [DATA_W-1:0] r_ram_dat;

  logic [DATA_W-1:0] r_a_dat;
  logic [DATA_W-1:0] r_b_dat;

  logic              w_resp_a;
  logic              w_resp_b;

  assign w_req_a   = a_cyc_i & b_zero_guard(a_stb_i);
  assign w_req_b   = b_cyc_i & b_zero_guard(b_stb_i);
  assign w_any_req = w_req_a | w_req_b;

  function automatic logic b_zero_guard(input logic v);
    return v;
  endfunction

  rr_arbiter2 u_rr (
    .req    ({w_req_b, w_req_a}),
    .last   (r_grant),
    .winner (w_winner)
  );

  // Request mux: selects the winning master's access fields.
  always_comb begin
    w_mux_we  = a_we_i;
    w_mux_adr = a_adr_i;
    w_mux_sel = a_sel_i;
    w_mux_dat = a_dat_i;
    if (w_winner == PORT_B) begin
      w_mux_we  = b_we_i;
      w_mux_adr = b_adr_i;
      w_mux_sel = b_sel_i;
      w_mux_dat = b_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM controls are loaded at the grant and held until the next grant;
  // only the write enable is confined to the ISSUE cycle. The async reset
  // clears the write enable mid-ISSUE so the RAM never commits that write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant   <= PORT_B;
      r_ram_we  <= 1'b0;
      r_ram_adr <= '0;
      r_ram_be  <= '0;
      r_ram_dat <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant   <= w_winner;
            r_ram_we  <= w_mux_we;
            r_ram_adr <= w_mux_adr;
            r_ram_be  <= w_mux_sel;
            r_ram_dat <= w_mux_dat;
          end
        end
        ISSUE:   r_ram_we <= 1'b0;
        default: r_ram_we <= 1'b0;
      endcase
    end
  end

  assign w_resp_a = (r_state == RESP) && (r_grant == PORT_A);
  assign w_resp_b = (r_state == RESP) && (r_grant == PORT_B);

  // Read data is forwarded live during RESP and captured so the port keeps
  // presenting the last value it was given.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a_dat <= '0;
      r_b_dat <= '0;
    end else begin
      if (w_resp_a) r_a_dat <= ram_dat_i;
      if (w_resp_b) r_b_dat <= ram_dat_i;
    end
  end

  assign a_dat_o   = w_resp_a ? ram_dat_i : r_a_dat;
  assign b_dat_o   = w_resp_b ? ram_dat_i : r_b_dat;
  assign a_ack_o   = w_resp_a & w_req_a;
  assign b_ack_o   = w_resp_b & w_req_b;

  assign ram_we_o  = r_ram_we;
  assign ram_adr_o = r_ram_adr;
  assign ram_be_o  = r_ram_be;
  assign ram_dat_o = r_ram_dat;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-port Wishbone-classic front end that shares the single-port on-chip RAM (4096 × 32-bit words, byte enables, one-cycle synchronous read) between the CPU instruction bus (port A) and data bus (port B). Sits between the two bus masters and the RAM macro. Grants one access at a time with two-way round-robin fairness, registers all RAM-side controls, and returns read data with a one-cycle ack per access.

## Interface
- ADDR_W, 12, word-address width; matches RAM depth of 4096.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- a_cyc_i, a_stb_i  in  1 each  port A cycle and strobe.
- a_we_i  in  1  port A write; port A is allowed to write.
- a_adr_i  in  ADDR_W  port A word address.
- a_sel_i  in  DATA_W/8  port A byte selects.
- a_dat_i  in  DATA_W  port A write data.
- a_dat_o  out  DATA_W  port A read data.
- a_ack_o  out  1  port A acknowledge.
- b_cyc_i, b_stb_i, b_we_i, b_adr_i, b_sel_i, b_dat_i, b_dat_o, b_ack_o: same as port A, for port B.
- ram_we_o  out  1  RAM write enable.
- ram_adr_o  out  ADDR_W  RAM address.
- ram_be_o  out  DATA_W/8  RAM byte enables.
- ram_dat_o  out  DATA_W  RAM write data.
- ram_dat_i  in  DATA_W  RAM registered read data.

## Operation
- A request on port X is req_X = X_cyc_i & X_stb_i.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if any req, pick winner, load ram_* registers from the winner's port, latch grant, go to ISSUE. Otherwise stay, with ram_we_o = 0.
  - ISSUE: ram_* hold the granted access. The RAM samples at the end of this cycle. Go to RESP.
  - RESP: ram_we_o = 0. Ack the granted port, then go to IDLE.
- Arbitration: single requester wins. If both request, the port not served last wins. last_grant resets to B, so A wins the first tie. last_grant updates only on a grant.
- Reads also drive ram_we_o = 0 and ram_be_o = sel. The RAM performs a full-word read regardless.
- Writes set ram_we_o = 1 during ISSUE only, with ram_be_o = sel_i. A write with sel = 0 is still acked and leaves memory unchanged.
- Read data: X_dat_o = ram_dat_i, passed combinationally in RESP for the granted port. Otherwise it holds the last value returned to that port. Reset value is 0.
- X_ack_o = (state == RESP) & (grant == X) & req_X. If the master drops cyc or stb before RESP, no ack is issued. A write already issued in ISSUE is not retracted.
- A request arriving while busy waits in the bus until the next IDLE; it is never lost.

## Timing
- Reset values: state IDLE, grant and last_grant B, ram_we_o 0, ram_adr_o 0, ram_be_o 0, ram_dat_o 0, both ack 0, both dat_o 0.
- Latency: request visible in cycle N (IDLE) → RAM access in N+1 → ack in N+2.
- Throughput: one access per 3 cycles. A master that holds stb through the ack cycle is re-granted only at IDLE in N+3, subject to round-robin.
- Both ports request continuously: grants alternate A, B, A, …; each port gets one ack per 6 cycles.
- rst_i asserted during ISSUE forces ram_we_o low asynchronously, so no write is committed at that edge. rst_i during RESP suppresses the ack.
- ack is never asserted for two consecutive cycles, nor on both ports in the same cycle.

## Structure
- Package ram_arb_pkg contains:
  - typedef enum {IDLE, ISSUE, RESP} arb_state_t;
  - typedef enum logic {PORT_A, PORT_B} port_t;
  - constants RAM_ADDR_W = 12 and RAM_DATA_W = 32.
- Sub-module rr_arbiter2: inputs req[1:0] and last; output winner.
- The top level holds the FSM, the request mux and the registered RAM controls.
- Verification instantiates the existing single-port RAM behind the arbiter.

## Test plan
- Port A reads word 5 (preloaded 0x1234_5678) → ram_adr_o = 5 in N+1; a_ack_o = 1 and a_dat_o = 0x1234_5678 in N+2; b_ack_o stays 0.
- Port B writes 0xDEAD_BEEF to word 7 with sel = 4'b0011, then reads it, with word 7 initially 0 → read returns 0x0000_BEEF.
- A and B both read continuously from reset → ack order A, B, A, B; 6 cycles between same-port acks.
- Port B drops stb during ISSUE of a read → no b_ack_o, FSM returns to IDLE in 2 cycles, and a following A request is served normally.
- rst_i pulsed during ISSUE of a B write of 0xFFFF_FFFF to word 3 → word 3 unchanged, all outputs at reset values immediately.
- Write with sel = 0 to word 9 holding 0xAAAA_5555 → b_ack_o asserted, word 9 still 0xAAAA_5555.
